// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer type and Gray conversions.
// The read-pointer controller uses the same package.
package fifo_pkg;

    localparam int FIFO_DEPTH     = 8;
    localparam int FIFO_PTR_WIDTH = 3;
    localparam int FIFO_AF_THRESH = 6;

    // Pointer with one extra wrap bit above the address bits
    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[FIFO_PTR_WIDTH] = g[FIFO_PTR_WIDTH];
        for (int i = FIFO_PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer/status controller for the async FIFO (wclk domain).
// Advances the binary write pointer and publishes a registered Gray pointer.
// From the synchronised Gray read pointer it derives full, almost_full,
// the fill level and a sticky overflow flag. All status is registered from
// next-state values, so full asserts on the edge that accepts the last slot.
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int PTR_WIDTH = FIFO_PTR_WIDTH,
    parameter int AF_THRESH = FIFO_AF_THRESH
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               w_en,
    input  logic               overflow_clr,
    input  logic [PTR_WIDTH:0] g_rptr_sync,
    output logic [PTR_WIDTH:0] b_wptr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic [PTR_WIDTH:0] wr_level,
    output logic               overflow
);

    localparam logic [PTR_WIDTH:0] L_AF = (PTR_WIDTH + 1)'(AF_THRESH);

    // Geometry sanity: the full rule needs Depth == 2**Ptr_Width and >= 2 address bits
    if (DEPTH != (1 << PTR_WIDTH) || PTR_WIDTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_cfg
        $error("fifo_wptr_ctrl: illegal DEPTH/PTR_WIDTH/AF_THRESH");
    end

    logic [PTR_WIDTH:0] r_bwptr;
    logic [PTR_WIDTH:0] r_gwptr;
    logic               r_full;
    logic               r_afull;
    logic [PTR_WIDTH:0] r_level;
    logic               r_ovf;

    logic               w_wr_acc;
    logic [PTR_WIDTH:0] w_bwptr_next;
    logic [PTR_WIDTH:0] w_gwptr_next;
    logic [PTR_WIDTH:0] w_rbin;
    logic [PTR_WIDTH:0] w_level_next;
    logic [PTR_WIDTH:0] w_rptr_full_cmp;
    logic               w_full_next;

    assign w_wr_acc     = w_en && !r_full;
    assign w_bwptr_next = r_bwptr + {{PTR_WIDTH{1'b0}}, w_wr_acc};
    assign w_gwptr_next = w_bwptr_next ^ (w_bwptr_next >> 1);

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted
    assign w_rptr_full_cmp = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
    assign w_full_next     = (w_gwptr_next == w_rptr_full_cmp);

    // Gray-to-binary of the synchronised read pointer, prefix XOR from the MSB
    always_comb begin
        w_rbin = '0;
        w_rbin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ g_rptr_sync[i];
        end
    end

    // Modulo subtraction stays in 0..DEPTH because pointers are at most one lap apart
    assign w_level_next = w_bwptr_next - w_rbin;

    // Pointer and status registers, all loaded from next-state values
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_bwptr <= '0;
            r_gwptr <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
        end else begin
            r_bwptr <= w_bwptr_next;
            r_gwptr <= w_gwptr_next;
            r_full  <= w_full_next;
            r_afull <= (w_level_next >= L_AF);
            r_level <= w_level_next;
        end
    end

    // Sticky overflow: a write attempt while full beats a same-cycle clear
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_ovf <= 1'b0;
        end else if (w_en && r_full) begin
            r_ovf <= 1'b1;
        end else if (overflow_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign b_wptr      = r_bwptr;
    assign g_wptr      = r_gwptr;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wr_level    = r_level;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed bench for fifo_wptr_ctrl: default build (AF=6) plus an AF=8 build.
module tb_fifo_wptr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       w_en, overflow_clr;
    logic [3:0] g_rptr_sync;
    logic [3:0] b_wptr, g_wptr, wr_level;
    logic       full, almost_full, overflow;

    logic       w_en8, clr8;
    logic [3:0] grptr8;
    logic [3:0] b_wptr8, g_wptr8, wr_level8;
    logic       full8, afull8, ovf8;

    int checks   = 0;
    int failures = 0;

    // Hand-written Gray code table for 0..15
    logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    fifo_wptr_ctrl #(.DEPTH(8), .PTR_WIDTH(3), .AF_THRESH(6)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en), .overflow_clr(overflow_clr),
        .g_rptr_sync(g_rptr_sync), .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
        .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
    );

    fifo_wptr_ctrl #(.DEPTH(8), .PTR_WIDTH(3), .AF_THRESH(8)) dut_af8 (
        .wclk(wclk), .wrst_n(wrst_n), .w_en(w_en8), .overflow_clr(clr8),
        .g_rptr_sync(grptr8), .b_wptr(b_wptr8), .g_wptr(g_wptr8), .full(full8),
        .almost_full(afull8), .wr_level(wr_level8), .overflow(ovf8)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        w_en = 0; overflow_clr = 0; g_rptr_sync = 0;
        w_en8 = 0; clr8 = 0; grptr8 = 0;
        wrst_n = 0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1;
        #1;
    endtask

    task automatic check_all(input string nm, input logic [3:0] eb, input logic ef,
                             input logic eaf, input logic [3:0] el, input logic eo);
        checks++;
        if (b_wptr !== eb || g_wptr !== GRAY[eb] || full !== ef || almost_full !== eaf ||
            wr_level !== el || overflow !== eo) begin
            failures++;
            $display("FAIL %s: got b=%h g=%h full=%b af=%b lvl=%0d ovf=%b, want b=%h g=%h full=%b af=%b lvl=%0d ovf=%b",
                     nm, b_wptr, g_wptr, full, almost_full, wr_level, overflow,
                     eb, GRAY[eb], ef, eaf, el, eo);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_all("reset_state", 4'd0, 0, 0, 4'd0, 0);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            w_en = 1;
            step();
            check_all($sformatf("fill_%0d", i), 4'(i), (i == 8), (i >= 6), 4'(i), 0);
        end
        w_en = 0;
    endtask

    task automatic test_overflow();
        // continues from full at b_wptr=8
        w_en = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("wr_while_full_%0d", i), 4'd8, 1, 1, 4'd8, 1);
        end
        w_en = 0; overflow_clr = 1;
        step();
        check_all("ovf_clear", 4'd8, 1, 1, 4'd8, 0);
        w_en = 1; overflow_clr = 1;
        step();
        check_all("ovf_set_beats_clr", 4'd8, 1, 1, 4'd8, 1);
        w_en = 0; overflow_clr = 0;
    endtask

    task automatic test_wrap_stream();
        logic [3:0] b, prev_g;
        do_reset();
        w_en = 1;
        repeat (3) step();
        check_all("stream_prefill", 4'd3, 0, 0, 4'd3, 0);
        b = 4'd3;
        for (int i = 0; i < 40; i++) begin
            prev_g = g_wptr;
            g_rptr_sync = GRAY[4'(b - 4'd2)];   // read pointer moves with the write
            step();
            b = b + 4'd1;
            check_all($sformatf("stream_%0d", i), b, 0, 0, 4'd3, 0);
            checks++;
            if ($countones(g_wptr ^ prev_g) !== 1) begin
                failures++;
                $display("FAIL gray_one_bit_%0d: got prev=%h now=%h, want exactly one bit change",
                         i, prev_g, g_wptr);
            end
        end
        w_en = 0;
        checks++;
        if (b !== 4'd11) begin
            failures++;
            $display("FAIL stream_end_ptr: got %h want b", b);
        end
    endtask

    task automatic test_read_release();
        do_reset();
        w_en = 1;
        repeat (8) step();
        check_all("rel_full", 4'd8, 1, 1, 4'd8, 0);
        g_rptr_sync = 4'b0001;   // one entry read; write in same cycle still rejected
        w_en = 1;
        step();
        check_all("rel_after_read", 4'd8, 0, 1, 4'd7, 1);
        w_en = 0;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        w_en = 1;
        repeat (5) step();
        check_all("pre_reset_lvl5", 4'd5, 0, 0, 4'd5, 0);
        #1;
        wrst_n = 0;
        #1;
        check_all("async_reset", 4'd0, 0, 0, 4'd0, 0);
        @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1;
        w_en = 1;
        step();
        check_all("resume_after_reset", 4'd1, 0, 0, 4'd1, 0);
        w_en = 0;
    endtask

    task automatic test_af8();
        do_reset();
        w_en8 = 1;
        repeat (7) step();
        checks++;
        if (afull8 !== 0 || full8 !== 0 || wr_level8 !== 4'd7) begin
            failures++;
            $display("FAIL af8_level7: got af=%b full=%b lvl=%0d, want af=0 full=0 lvl=7",
                     afull8, full8, wr_level8);
        end
        step();
        checks++;
        if (afull8 !== 1 || full8 !== 1 || wr_level8 !== 4'd8 || b_wptr8 !== 4'd8) begin
            failures++;
            $display("FAIL af8_level8: got af=%b full=%b lvl=%0d b=%h, want af=1 full=1 lvl=8 b=8",
                     afull8, full8, wr_level8, b_wptr8);
        end
        w_en8 = 0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap_stream();
        test_read_release();
        test_midstream_reset();
        test_af8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
Write-side pointer and status controller for the asynchronous FIFO, in the wclk domain, directly upstream of the FIFO storage array. It accepts write requests and advances the binary write pointer that addresses the memory. It publishes a Gray-coded write pointer for synchronisation into the read domain. From the already-synchronised Gray read pointer it derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
Depth, 8, FIFO entries; must equal 2**Ptr_Width.
Ptr_Width, 3, address bits; pointers carry one extra wrap bit (Ptr_Width+1 bits total).
AF_Thresh, 6, level at or above which almost_full asserts; legal range 1..Depth.

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  asynchronous active-low reset
w_en  input  1  write request from producer
overflow_clr  input  1  clears sticky overflow flag
g_rptr_sync  input  Ptr_Width+1  Gray read pointer, already 2-flop synchronised into wclk
b_wptr  output  Ptr_Width+1  binary write pointer to memory; low Ptr_Width bits address it
g_wptr  output  Ptr_Width+1  Gray write pointer, to read-domain synchroniser
full  output  1  FIFO full; memory write gate
almost_full  output  1  level >= AF_Thresh
wr_level  output  Ptr_Width+1  write-side fill level, 0..Depth
overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (wrst_n low, async assert, sync release): b_wptr=0, g_wptr=0, full=0, almost_full=0, wr_level=0, overflow=0. Reset mid-stream discards all pointer state immediately; the read side must be reset in the same window.
- Write accept: wr_acc = w_en && !full. On the wclk edge with wr_acc, b_wptr <= b_wptr+1, modulo 2**(Ptr_Width+1), wrapping from all-ones to 0. Otherwise b_wptr holds.
- g_wptr is registered: g_wptr <= b_wptr_next ^ (b_wptr_next >> 1). Only one bit changes per accepted write. g_wptr is never driven combinationally.
- full is registered from next-state values: full <= (g_wptr_next == {~g_rptr_sync[Ptr_Width:Ptr_Width-1], g_rptr_sync[Ptr_Width-2:0]}). It asserts on the same edge that accepts the Depth-th outstanding write. There is zero-cycle latency from the accepting edge.
- b_rptr_conv = Gray-to-binary of g_rptr_sync, as a prefix XOR from the MSB down.
- wr_level <= b_wptr_next - b_rptr_conv, unsigned, modulo 2**(Ptr_Width+1). The result lies in the range 0..Depth.
- Because g_rptr_sync lags, wr_level, full and almost_full are pessimistic: they deassert 2-3 wclk cycles after a read. This is intended and safe.
- almost_full <= (wr_level_next >= AF_Thresh), registered.
- Write while full is ignored: the pointer holds and memory is not written.
- overflow: set on the edge where w_en && full. It clears on overflow_clr. If set and clear occur in the same cycle, set wins.
- Simultaneous write accept and read-pointer advance: the level uses both new values. It may be unchanged, and full deasserts only if the result is < Depth.
- Pointer wrap: full detection relies on the MSB-pair inversion rule. It must hold across every wrap of both pointers.

Decomposition:
- fifo_pkg holds DEPTH/PTR_WIDTH defaults, the pointer typedef logic [PTR_WIDTH:0], and functions bin2gray and gray2bin. These are shared with the read-pointer controller.
- One natural sub-module, fifo_sync2: a 2-flop synchroniser, instantiated in the top-level, not here. This block receives g_rptr_sync already synchronised.

Test Plan:
1. Reset, then 8 consecutive writes with g_rptr_sync=0 -> b_wptr steps 0..8. full=1 on the 8th accepting edge. wr_level=8. almost_full=1 on the edge that makes level 6.
2. At full, w_en held 3 cycles -> b_wptr stays 8 (4'b1000), overflow=1 and stays set. overflow_clr pulse -> overflow=0 next edge. Clear and write-while-full in the same cycle -> overflow stays 1.
3. Stream 40 writes while g_rptr_sync tracks Gray(b_wptr-3) -> b_wptr wraps 15->0 correctly. g_wptr changes exactly one bit per write. full never asserts. wr_level stays 3.
4. Full with b_wptr=8, g_rptr_sync=0 -> drive g_rptr_sync=Gray(1)=4'b0001. full=0 and wr_level=7 next edge. A write in that same cycle is rejected (full was 1), so b_wptr stays 8.
5. wrst_n asserted mid-burst at level 5 -> all outputs 0 asynchronously, before the next wclk edge. Writes resume from b_wptr=0 after release.
6. AF_Thresh=8 build, fill to 7 -> almost_full=0. 8th write -> almost_full=1 and full=1 on the same edge.
